// File: rtl/data_memory_responder.sv
// Wait-state data-memory responder with an internal word array and a debug read port.
// Define DATA_MEM_BYTE_EN to add the memoryByteEnable per-byte write mask.
module data_memory_responder #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          memoryAddress,
    input  logic                 memoryReadEnable,
    input  logic                 memoryWriteEnable,
    input  logic [31:0]          memoryWriteData,
`ifdef DATA_MEM_BYTE_EN
    input  logic [3:0]           memoryByteEnable,
`endif
    output logic [31:0]          memoryReadData,
    output logic                 memoryReady,
    output logic                 memoryBusy,
    input  logic [ADDR_BITS-1:0] debugAddress,
    output logic [31:0]          debugReadData
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_cnt;
    logic [ADDR_BITS-1:0] r_index;
    logic [31:0]          r_wdata;
    logic                 r_write;
    logic [3:0]           r_be;
    logic [31:0]          r_read_data;
    logic [31:0]          r_mem [2**ADDR_BITS];

    logic                 w_req;
    logic                 w_idle_go;
    logic                 w_commit;
    logic [ADDR_BITS-1:0] w_acc_index;
    logic [31:0]          w_acc_wdata;
    logic                 w_acc_write;
    logic [3:0]           w_acc_be;
    logic [3:0]           w_in_be;
    logic [31:0]          w_old;
    logic [31:0]          w_merged;
    logic [ADDR_BITS+3:0] w_unused_addr;

    assign w_unused_addr = {memoryAddress[31:ADDR_BITS+2], memoryAddress[1:0]};

`ifdef DATA_MEM_BYTE_EN
    assign w_in_be = memoryByteEnable;
`else
    assign w_in_be = 4'hF;
`endif

    assign w_req     = memoryReadEnable | memoryWriteEnable;
    assign w_idle_go = (r_state == ST_IDLE) && w_req;

    // With zero wait states the commit happens on the sampling edge, so the access
    // must be taken from the live inputs rather than the latched copy.
    assign w_acc_index = (r_state == ST_IDLE) ? memoryAddress[ADDR_BITS+1:2] : r_index;
    assign w_acc_wdata = (r_state == ST_IDLE) ? memoryWriteData : r_wdata;
    assign w_acc_write = (r_state == ST_IDLE) ? memoryWriteEnable : r_write;
    assign w_acc_be    = (r_state == ST_IDLE) ? w_in_be : r_be;

    assign w_commit = !rst && ((w_idle_go && (WAIT_CYCLES == 0)) ||
                               ((r_state == ST_WAIT) && (r_cnt == 4'd0)));

    assign w_old = r_mem[w_acc_index];

    always_comb begin
        w_merged = w_old;
        for (int unsigned b = 0; b < 4; b++) begin
            if (w_acc_be[b]) w_merged[8*b +: 8] = w_acc_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_next = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd0) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_index     <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_be        <= '0;
            r_read_data <= '0;
        end else begin
            if (w_idle_go) begin
                r_cnt   <= CNT_INIT;
                r_index <= memoryAddress[ADDR_BITS+1:2];
                r_wdata <= memoryWriteData;
                r_write <= memoryWriteEnable;
                r_be    <= w_in_be;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) r_read_data <= w_old;
        end
    end

    // Array contents survive reset; only the control path is cleared.
    always_ff @(posedge clk) begin
        if (w_commit && w_acc_write) r_mem[w_acc_index] <= w_merged;
    end

    assign memoryReadData = r_read_data;
    assign memoryReady    = (r_state == ST_DONE);
    assign memoryBusy     = (r_state != ST_IDLE);
    assign debugReadData  = r_mem[debugAddress];

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: directed test-plan vectors plus random traffic
// against an array reference model; a second instance checks zero-wait-state throughput.
module tb_data_memory_responder;
    localparam int unsigned AB     = 10;
    localparam int unsigned WAIT_A = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0]   a_addr, a_wdata, a_rdata, a_dbg_data;
    logic          a_re, a_we, a_ready, a_busy;
    logic [AB-1:0] a_dbg_addr;
    logic [31:0]   b_addr, b_wdata, b_rdata, b_dbg_data;
    logic          b_re, b_we, b_ready, b_busy;
    logic [AB-1:0] b_dbg_addr;
`ifdef DATA_MEM_BYTE_EN
    logic [3:0]    a_be, b_be;
`endif

    data_memory_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(WAIT_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .memoryAddress(a_addr), .memoryReadEnable(a_re), .memoryWriteEnable(a_we),
        .memoryWriteData(a_wdata),
`ifdef DATA_MEM_BYTE_EN
        .memoryByteEnable(a_be),
`endif
        .memoryReadData(a_rdata), .memoryReady(a_ready), .memoryBusy(a_busy),
        .debugAddress(a_dbg_addr), .debugReadData(a_dbg_data)
    );

    data_memory_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .memoryAddress(b_addr), .memoryReadEnable(b_re), .memoryWriteEnable(b_we),
        .memoryWriteData(b_wdata),
`ifdef DATA_MEM_BYTE_EN
        .memoryByteEnable(b_be),
`endif
        .memoryReadData(b_rdata), .memoryReady(b_ready), .memoryBusy(b_busy),
        .debugAddress(b_dbg_addr), .debugReadData(b_dbg_data)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] dbg;
        int unsigned due;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [2**AB];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? wd[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    task automatic access_a(input logic [31:0] addr, input logic we, input logic re,
                            input logic [31:0] wd, input logic [3:0] be);
        exp_t          e;
        logic [AB-1:0] idx;
        logic [3:0]    m;
        bit            seen;
        int            waited;
`ifdef DATA_MEM_BYTE_EN
        m = be;
`else
        m = 4'hF | be;
`endif
        @(posedge clk); #1;
        a_addr = addr; a_we = we; a_re = re; a_wdata = wd;
`ifdef DATA_MEM_BYTE_EN
        a_be = be;
`endif
        idx = addr[AB+1:2];
        a_dbg_addr = idx;
        e.rdata = model[idx];
        if (we) model[idx] = merge(model[idx], wd, m);
        e.dbg = model[idx];
        e.due = cyc + 1 + WAIT_A;
        sbq.push_back(e);
        seen = 0; waited = 0;
        while (!seen && waited < 64) begin
            @(negedge clk);
            if (a_ready) seen = 1;
            waited++;
        end
        if (!seen) chk("a_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        a_we = 0; a_re = 0;
    endtask

    int unsigned busy_run   = 0;
    bit          prev_ready = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_run   = 0;
            prev_ready = 0;
        end else begin
            if (a_busy) busy_run++;
            if (a_ready) begin
                if (prev_ready) chk("a_ready_consecutive", 32'd1, 32'd0);
                if (sbq.size() == 0) chk("a_spurious_ready", 32'd1, 32'd0);
                else begin
                    e = sbq.pop_front();
                    chk("a_rdata", a_rdata, e.rdata);
                    chk("a_debug", a_dbg_data, e.dbg);
                    chk("a_latency", cyc, e.due);
                    chk("a_busy_cycles", busy_run, WAIT_A + 1);
                end
                busy_run = 0;
            end
            prev_ready = a_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        int          pulses, last_pulse;
        logic [31:0] addr;
        int unsigned idx, kind;

        rst = 1;
        a_addr = 0; a_we = 0; a_re = 0; a_wdata = 0; a_dbg_addr = 0;
        b_addr = 0; b_we = 0; b_re = 0; b_wdata = 0; b_dbg_addr = 0;
`ifdef DATA_MEM_BYTE_EN
        a_be = 4'hF; b_be = 4'hF;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_rdata", a_rdata, 32'h0);
        chk("rst_b_rdata", b_rdata, 32'h0);
        rst = 0;

        // Zero wait states: one write, then reads held continuously.
        @(posedge clk); #1;
        b_addr = 32'hFFFF_FC0C; b_we = 1; b_wdata = 32'hCAFEF00D; b_dbg_addr = 10'h303;
        seen = 0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            if (b_ready) seen = 1;
        end
        chk("b_write_ready", {31'd0, seen}, 32'd1);
        chk("b_debug", b_dbg_data, 32'hCAFEF00D);
        @(posedge clk); #1;
        b_we = 0; b_re = 1; b_addr = 32'h0000_0C0E;
        pulses = 0; last_pulse = -10;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("b_busy_eq_ready", {31'd0, b_busy}, {31'd0, b_ready});
            if (b_ready) begin
                if (k - last_pulse != 2 && last_pulse >= 0) chk("b_pulse_gap", k - last_pulse, 32'd2);
                chk("b_rdata", b_rdata, 32'hCAFEF00D);
                last_pulse = k;
                pulses++;
            end
        end
        chk("b_pulse_count", pulses, 32'd10);
        @(posedge clk); #1;
        b_re = 0;

        // Directed test-plan vectors.
        access_a(32'h0000_0010, 1, 0, 32'hDEADBEEF, 4'hF);
        access_a(32'h0000_0010, 0, 1, 32'h0, 4'hF);
        access_a(32'h0000_0010, 1, 1, 32'h12345678, 4'hF);
        chk("both_en_array", a_dbg_data, 32'h12345678);

        // Reset during the wait states of a write must discard it.
        access_a(32'h0000_0020, 1, 0, 32'h55AA55AA, 4'hF);
        @(posedge clk); #1;
        a_addr = 32'h0000_0020; a_we = 1; a_wdata = 32'h0; a_dbg_addr = 8;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", {31'd0, a_busy}, 32'd1);
        rst = 1; #1;
        chk("abort_ready", {31'd0, a_ready}, 32'd0);
        chk("abort_busy", {31'd0, a_busy}, 32'd0);
        chk("abort_rdata", a_rdata, 32'h0);
        @(posedge clk); #1;
        a_we = 0;
        @(negedge clk);
        rst = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_mem8", a_dbg_data, 32'h55AA55AA);

`ifdef DATA_MEM_BYTE_EN
        access_a(32'h0000_0040, 1, 0, 32'h0, 4'hF);
        access_a(32'h0000_0040, 1, 0, 32'hAABBCCDD, 4'b0101);
        chk("byte_en_word", a_dbg_data, 32'h00BB00DD);
        access_a(32'h0000_0040, 1, 0, 32'hFFFFFFFF, 4'b0000);
        chk("byte_en_none", a_dbg_data, 32'h00BB00DD);
`endif

        // Preload a small aliased window, then random traffic.
        for (int i = 0; i < 16; i++) access_a(i * 4, 1, 0, $urandom, 4'hF);
        for (int n = 0; n < 60; n++) begin
            idx  = $urandom_range(0, 15);
            kind = $urandom_range(0, 2);
            addr = ($urandom & 32'hFFFF_F000) | (idx << 2) | $urandom_range(0, 3);
            access_a(addr, kind != 0, kind != 1, $urandom, 4'($urandom));
        end

        repeat (8) @(posedge clk);
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Responder end of the CPU data-memory port: accepts read/write requests from the 5-stage datapath's `memoryAddress`/`memoryReadEnable`/`memoryWriteEnable`/`memoryWriteData` outputs and returns `memoryReadData` with a `memoryReady` handshake. The storage is an internal word-addressed register array, and latency is a configurable number of wait states. The block is a drop-in behavioural replacement for the vendor RAM IP in simulation and lets the pipeline's stall logic be exercised against multi-cycle memory.

## Interface
- `ADDR_BITS`, default 10: word-index width; depth = 2^ADDR_BITS words of 32 bits.
- `WAIT_CYCLES`, default 2: wait states inserted before `memoryReady`; legal range 0..15.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `memoryAddress` input 32: byte address; word index = `memoryAddress[ADDR_BITS+1:2]`.
- `memoryReadEnable` input 1: read request, held until `memoryReady`.
- `memoryWriteEnable` input 1: write request, held until `memoryReady`.
- `memoryWriteData` input 32: write data, held stable with the request.
- `memoryByteEnable` input 4: per-byte write mask; bit i maps to bits [8i+7:8i]. Present only with `DATA_MEM_BYTE_EN`.
- `memoryReadData` output 32: registered read data, valid while `memoryReady` = 1.
- `memoryReady` output 1: one-cycle completion pulse.
- `memoryBusy` output 1: high in WAIT and DONE.
- `debugAddress` input ADDR_BITS: word index for the debug read port.
- `debugReadData` output 32: combinational read of `mem[debugAddress]`.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE: on an edge where a request (`memoryReadEnable` | `memoryWriteEnable`) is seen:
  - latch the word index, write data and type;
  - go to DONE if `WAIT_CYCLES` = 0;
  - otherwise go to WAIT with counter = `WAIT_CYCLES` - 1.
- WAIT: decrement the counter each edge. On the edge where the counter = 0, go to DONE.
- Entering DONE, on that same edge:
  - a write commits to the array;
  - `memoryReadData` loads `mem[index]`, which is the pre-write contents on a write.
- DONE: `memoryReady` = 1 for exactly one cycle, then go unconditionally to IDLE. A request present on the DONE→IDLE edge is not sampled.
- Both enables high: treated as a write; `memoryReadData` returns the old word.
- Address handling:
  - address bits [1:0] are ignored (no misalignment trap);
  - bits above ADDR_BITS+1 are ignored (aliasing).
- Inputs are latched in IDLE. Changes to the inputs during WAIT/DONE do not affect the access in flight.
- Array contents are not reset. Only the FSM, counter, latched request and outputs are reset.

## Timing
- Reset values: `memoryReady` = 0, `memoryBusy` = 0, `memoryReadData` = 32'h0, state IDLE, counter 0.
- Latency: request sampled at edge E0; `memoryReady` is high during the cycle after edge E0 + `WAIT_CYCLES`.
- Throughput: at most one access per `WAIT_CYCLES` + 2 cycles, because of the mandatory IDLE bubble after DONE.
- `memoryReadData` holds its value after DONE until the next DONE or reset.
- Reset mid-access: immediate return to IDLE, outputs go to their reset values, and an uncommitted write is discarded.
- Debug port: pure combinational read. It reflects a write in the cycle after the committing edge.

## Configuration
- `DATA_MEM_BYTE_EN` defined:
  - the `memoryByteEnable` port exists and is latched in IDLE;
  - on commit, only bytes with the mask bit = 1 are written;
  - mask 4'b0000 completes the handshake with no array change.
- `DATA_MEM_BYTE_EN` undefined: no port; every write replaces the full 32-bit word.

## Test plan
- Reset, then write 32'hDEADBEEF to 0x10 with `WAIT_CYCLES` = 2:
  - `memoryReady` pulses in cycle 3 after the request edge;
  - `debugAddress` = 4 then reads 32'hDEADBEEF.
- Read 0x10 after that write: `memoryReadData` = 32'hDEADBEEF in the ready cycle; `memoryBusy` is high for 3 cycles.
- `WAIT_CYCLES` = 0, back-to-back reads held continuously: a ready pulse every 2 cycles, never on consecutive cycles.
- Both enables, address 0x10, data 32'h12345678:
  - `memoryReadData` = 32'hDEADBEEF;
  - the array then holds 32'h12345678.
- Assert `rst` during WAIT of a write to 0x20 holding 32'h0: `memoryReady` = 0 and `mem[8]` is unchanged.
- With `DATA_MEM_BYTE_EN`: write 32'hAABBCCDD with mask 4'b0101 over 32'h0 → word = 32'h00BB00DD.
